// File: rtl/mul_share_ctrl.sv
// Shared multiplier controller: arbitrates two requesters onto one
// shift/accumulate datapath and sequences its load/clear/decrement strobes.
module mul_share_ctrl #(
    parameter int MAXITER = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       eqz_i,
    output logic [1:0] gnt_o,
    output logic       sel_o,
    output logic       LdA_o,
    output logic       LdB_o,
    output logic       LdP_o,
    output logic       clrP_o,
    output logic       decB_o,
    output logic [1:0] done_o,
    output logic       err_o,
    output logic       busy_o
);

    localparam logic [7:0] S_IDLE = 8'd0;
    localparam logic [7:0] S_LDA  = 8'd1;
    localparam logic [7:0] S_LDB  = 8'd2;
    localparam logic [7:0] S_CHK  = 8'd3;
    localparam logic [7:0] S_ACC  = 8'd4;
    localparam logic [7:0] S_DONE = 8'd5;

    localparam logic [7:0] MAX_C = 8'(MAXITER);

    logic [7:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] gnt_q, gnt_d;
    logic       sel_q, sel_d;
    logic       last_q, last_d;
    logic       abort_q, abort_d;
    logic       win;

    // Round-robin pick: a lone requester wins, a tie goes to the one
    // that did not win last time.
    always_comb begin
        win = ~last_q;
        if (!req_i[1]) begin
            win = 1'b0;
        end else if (!req_i[0]) begin
            win = 1'b1;
        end
    end

    // State, iteration counter, grant and round-robin pointer registers.
    // The pointer resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            gnt_q   <= 2'b00;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            abort_q <= abort_d;
        end
    end

    // Next-state logic, including grant capture and iteration limit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        abort_d = abort_q;
        case (state_q)
            S_IDLE: begin
                if (req_i != 2'b00) begin
                    state_d = S_LDA;
                    sel_d   = win;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    last_d  = win;
                end
            end
            S_LDA: begin
                state_d = S_LDB;
            end
            S_LDB: begin
                cnt_d   = 8'd0;
                abort_d = 1'b0;
                state_d = S_CHK;
            end
            S_CHK: begin
                state_d = eqz_i ? S_DONE : S_ACC;
            end
            S_ACC: begin
                if (eqz_i) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == MAX_C) begin
                        state_d = S_DONE;
                        abort_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
                gnt_d   = 2'b00;
                sel_d   = 1'b0;
                abort_d = 1'b0;
            end
        endcase
    end

    // Moore strobes per state; ACC strobes are gated by the live eqz.
    // Unknown encodings fall to the all-zero default.
    always_comb begin
        LdA_o  = 1'b0;
        LdB_o  = 1'b0;
        LdP_o  = 1'b0;
        clrP_o = 1'b0;
        decB_o = 1'b0;
        done_o = 2'b00;
        err_o  = 1'b0;
        busy_o = 1'b0;
        gnt_o  = 2'b00;
        sel_o  = 1'b0;
        case (state_q)
            S_LDA: begin
                LdA_o  = 1'b1;
                clrP_o = 1'b1;
                busy_o = 1'b1;
            end
            S_LDB: begin
                LdB_o  = 1'b1;
                busy_o = 1'b1;
            end
            S_CHK: begin
                busy_o = 1'b1;
            end
            S_ACC: begin
                LdP_o  = ~eqz_i;
                decB_o = ~eqz_i;
                busy_o = 1'b1;
            end
            S_DONE: begin
                done_o = sel_q ? 2'b10 : 2'b01;
                err_o  = abort_q;
                busy_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
        if (busy_o) begin
            gnt_o = gnt_q;
            sel_o = sel_q;
        end
    end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Randomised self-checking bench for mul_share_ctrl with a behavioural
// operand register model and a transaction-level expectation model.
module tb_mul_share_ctrl;

    localparam int MAXI = 4;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic       eqz;
    logic [1:0] gnt_o;
    logic       sel_o;
    logic       LdA_o, LdB_o, LdP_o, clrP_o, decB_o;
    logic [1:0] done_o;
    logic       err_o;
    logic       busy_o;

    logic [7:0] b_reg;
    logic [7:0] opb [2];
    logic       stuck;
    logic       last_w;

    int tests_run;
    int fails;

    mul_share_ctrl #(.MAXITER(MAXI)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_i  (req),
        .eqz_i  (eqz),
        .gnt_o  (gnt_o),
        .sel_o  (sel_o),
        .LdA_o  (LdA_o),
        .LdB_o  (LdB_o),
        .LdP_o  (LdP_o),
        .clrP_o (clrP_o),
        .decB_o (decB_o),
        .done_o (done_o),
        .err_o  (err_o),
        .busy_o (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand B register of the external datapath.
    always @(posedge clk) begin
        if (LdB_o) b_reg <= opb[sel_o];
        else if (decB_o) b_reg <= b_reg - 8'd1;
    end

    assign eqz = stuck ? 1'b0 : (b_reg == 8'd0);

    function automatic logic [11:0] outs();
        return {gnt_o, sel_o, LdA_o, LdB_o, LdP_o, clrP_o, decB_o,
                done_o, err_o, busy_o};
    endfunction

    // Expected winner from the round-robin rule.
    function automatic logic exp_winner(input logic [1:0] r);
        if (r == 2'b01) return 1'b0;
        if (r == 2'b10) return 1'b1;
        return ~last_w;
    endfunction

    // Drives one transaction and measures it; called at a negedge.
    task automatic run_op(input logic [1:0] r, input bit drop_early,
                          input bit keep, output logic [1:0] w,
                          output int wt, output int lat, output int np,
                          output logic e, output logic [1:0] dn,
                          output int viol, output bit to);
        w = 0; wt = 0; lat = 0; np = 0; e = 0; dn = 0; viol = 0; to = 1;
        req = r;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (gnt_o != 2'b00) begin
                to = 0;
                wt = k;
                break;
            end
        end
        if (to) return;
        w = gnt_o;
        if (!(LdA_o && clrP_o)) viol++;
        if (drop_early) req = 2'b00;
        to = 1;
        for (int k = 0; k < 40; k++) begin
            if (int'(LdA_o) + int'(LdB_o) + int'(LdP_o) > 1) viol++;
            if (!busy_o || gnt_o != w) viol++;
            np += int'(LdP_o);
            if (done_o != 2'b00) begin
                dn = done_o;
                e = err_o;
                to = 0;
                if (!keep) req = req & ~done_o;
                break;
            end
            if (err_o) viol++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 2'b00;
        stuck = 1'b0;
        opb[0] = 0;
        opb[1] = 0;
        b_reg = 0;
        last_w = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (outs() !== 12'd0) begin
            fails++;
            $display("FAIL reset_outputs got=%h exp=000", outs());
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (outs() !== 12'd0) begin
            fails++;
            $display("FAIL idle_outputs got=%h exp=000", outs());
        end
    endtask

    task automatic test_single();
        logic [9:0] got, exp;
        opb[0] = 8'd3;
        req = 2'b01;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            // {gnt, LdA, LdB, LdP, clrP, decB, done, err}
            case (c)
                0: exp = 10'b01_1_0_0_1_0_00_0;
                1: exp = 10'b01_0_1_0_0_0_00_0;
                3, 4, 5: exp = 10'b01_0_0_1_0_1_00_0;
                7: exp = 10'b01_0_0_0_0_0_01_0;
                default: exp = 10'b01_0_0_0_0_0_00_0;
            endcase
            got = {gnt_o, LdA_o, LdB_o, LdP_o, clrP_o, decB_o,
                   done_o, err_o};
            tests_run++;
            if (got !== exp) begin
                fails++;
                $display("FAIL single_cycle%0d got=%b exp=%b", c, got, exp);
            end
        end
        req = 2'b00;
        last_w = 1'b0;
    endtask

    task automatic test_zero();
        logic [1:0] w, dn;
        int wt, lat, np, viol;
        logic e;
        bit to;
        opb[1] = 8'd0;
        run_op(2'b10, 0, 0, w, wt, lat, np, e, dn, viol, to);
        last_w = 1'b1;
        tests_run++;
        if ({to, w, dn, e} !== {1'b0, 2'b10, 2'b10, 1'b0}
            || lat != 3 || np != 0 || viol != 0) begin
            fails++;
            $display("FAIL zero_operand to=%0d w=%b dn=%b e=%b lat=%0d np=%0d viol=%0d exp w=10 dn=10 e=0 lat=3 np=0",
                     to, w, dn, e, lat, np, viol);
        end
    endtask

    task automatic test_abort();
        logic [1:0] w, dn;
        int wt, lat, np, viol;
        logic e;
        bit to;
        stuck = 1'b1;
        opb[0] = 8'd2;
        run_op(2'b01, 0, 0, w, wt, lat, np, e, dn, viol, to);
        last_w = 1'b0;
        stuck = 1'b0;
        tests_run++;
        if (to || np != MAXI || e !== 1'b1 || dn !== 2'b01) begin
            fails++;
            $display("FAIL abort_pulses to=%0d np=%0d e=%b dn=%b exp np=%0d e=1 dn=01",
                     to, np, e, dn, MAXI);
        end
        tests_run++;
        if (viol != 0 || lat != 3 + MAXI) begin
            fails++;
            $display("FAIL abort_timing viol=%0d lat=%0d exp viol=0 lat=%0d",
                     viol, lat, 3 + MAXI);
        end
        @(negedge clk);
        tests_run++;
        if ({err_o, done_o, busy_o} !== 4'b0) begin
            fails++;
            $display("FAIL abort_oneshot got=%b exp=0000",
                     {err_o, done_o, busy_o});
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] w, dn;
        int wt, lat, np, viol;
        logic e;
        bit to;
        opb[0] = 8'd1;
        run_op(2'b01, 0, 1, w, wt, lat, np, e, dn, viol, to);
        tests_run++;
        if (to || dn !== 2'b01 || lat != 5) begin
            fails++;
            $display("FAIL b2b_first to=%0d dn=%b lat=%0d exp dn=01 lat=5",
                     to, dn, lat);
        end
        run_op(2'b01, 0, 0, w, wt, lat, np, e, dn, viol, to);
        last_w = 1'b0;
        tests_run++;
        if (to || w !== 2'b01 || wt != 1 || dn !== 2'b01) begin
            fails++;
            $display("FAIL b2b_regrant to=%0d w=%b wt=%0d dn=%b exp w=01 wt=1 dn=01",
                     to, w, wt, dn);
        end
    endtask

    task automatic test_req_drop();
        logic [1:0] w, dn;
        int wt, lat, np, viol;
        logic e;
        bit to;
        opb[1] = 8'd2;
        run_op(2'b10, 1, 0, w, wt, lat, np, e, dn, viol, to);
        last_w = 1'b1;
        tests_run++;
        if (to || dn !== 2'b10 || lat != 6 || np != 2 || viol != 0) begin
            fails++;
            $display("FAIL req_drop to=%0d dn=%b lat=%0d np=%0d viol=%0d exp dn=10 lat=6 np=2",
                     to, dn, lat, np, viol);
        end
    endtask

    task automatic test_contention();
        logic [1:0] w, dn;
        int wt, lat, np, viol;
        logic e;
        bit to;
        logic [1:0] ew;
        @(negedge clk);
        rst_n = 1'b0;
        req = 2'b11;
        opb[0] = 8'd1;
        opb[1] = 8'd2;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_w = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ew = (i % 2 == 0) ? 2'b01 : 2'b10;
            run_op(2'b11, 0, 1, w, wt, lat, np, e, dn, viol, to);
            last_w = ew[1];
            tests_run++;
            if (to || w !== ew || dn !== ew || viol != 0) begin
                fails++;
                $display("FAIL contention%0d to=%0d w=%b dn=%b viol=%0d exp=%b",
                         i, to, w, dn, viol, ew);
            end
        end
        req = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        logic [1:0] w, dn, r;
        int wt, lat, np, viol;
        logic e;
        bit to;
        logic ew;
        int b, enp, elat;
        logic eerr;
        for (int i = 0; i < 30; i++) begin
            r = 2'($urandom_range(1, 3));
            opb[0] = 8'($urandom_range(0, 6));
            opb[1] = 8'($urandom_range(0, 6));
            ew = exp_winner(r);
            b = int'(opb[ew]);
            eerr = (b >= MAXI);
            enp = eerr ? MAXI : b;
            elat = (b == 0) ? 3 : (eerr ? 3 + MAXI : 4 + b);
            run_op(r, 0, 0, w, wt, lat, np, e, dn, viol, to);
            last_w = ew;
            tests_run++;
            if (to || w !== {ew, ~ew} || dn !== {ew, ~ew}) begin
                fails++;
                $display("FAIL rand%0d_grant r=%b to=%0d w=%b dn=%b exp=%b",
                         i, r, to, w, dn, {ew, ~ew});
            end
            tests_run++;
            if (lat != elat || np != enp || e !== eerr || viol != 0) begin
                fails++;
                $display("FAIL rand%0d_op B=%0d lat=%0d np=%0d e=%b viol=%0d exp lat=%0d np=%0d e=%b",
                         i, b, lat, np, e, viol, elat, enp, eerr);
            end
        end
    endtask

    task automatic test_reset_mid_acc();
        logic [1:0] w, dn;
        int wt, lat, np, viol;
        logic e;
        bit to;
        bit seen, bad;
        req = 2'b00;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!busy_o) break;
        end
        opb[0] = 8'd6;
        req = 2'b01;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (LdP_o) begin
                seen = 1;
                break;
            end
        end
        tests_run++;
        if (!seen) begin
            fails++;
            $display("FAIL rst_acc_reach got=0 exp=1");
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (outs() !== 12'd0) begin
            fails++;
            $display("FAIL rst_async got=%h exp=000", outs());
        end
        req = 2'b11;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_o != 2'b00 || busy_o) bad = 1;
        end
        tests_run++;
        if (bad) begin
            fails++;
            $display("FAIL rst_hold got=active exp=idle");
        end
        rst_n = 1'b1;
        last_w = 1'b1;
        #1;
        tests_run++;
        if (gnt_o !== 2'b00) begin
            fails++;
            $display("FAIL rst_early_grant got=%b exp=00", gnt_o);
        end
        opb[0] = 8'd1;
        run_op(2'b11, 0, 0, w, wt, lat, np, e, dn, viol, to);
        tests_run++;
        if (to || w !== 2'b01 || wt != 0 || dn !== 2'b01) begin
            fails++;
            $display("FAIL rst_priority to=%0d w=%b wt=%0d dn=%b exp w=01 wt=0 dn=01",
                     to, w, wt, dn);
        end
        req = 2'b00;
    endtask

    initial begin
        tests_run = 0;
        fails = 0;
        test_reset();
        test_single();
        test_zero();
        test_abort();
        test_back_to_back();
        test_req_drop();
        test_contention();
        test_random();
        test_reset_mid_acc();
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
